// File: rtl/generic_dpram_1clk.sv
// Single-clock simple dual-port RAM: one write port, one registered read port, output gated by oe.
// Define GENERIC_DPRAM_WRITE_FIRST_EN to forward same-address write data to the read port.
module generic_dpram_1clk #(
    parameter int aw = 8,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rce,
    input  logic          oe,
    input  logic [aw-1:0] raddr,
    output logic [dw-1:0] dout,
    input  logic          wce,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  logic [dw-1:0] di
);

    localparam int depth = 32'd1 << aw;

    logic [dw-1:0] mem_r [0:depth-1];
    logic [dw-1:0] rdata_r;
    logic [dw-1:0] rdata_s;
    logic          wr_en_s;

    assign wr_en_s = wce & we & ~rst;

    // Memory array write port; the array itself carries no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[waddr] <= di;
        end
    end

    // Read data register: async clear, updates only on read enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {dw{1'b0}};
        end else if (rce) begin
            rdata_r <= mem_r[raddr];
        end
    end

`ifdef GENERIC_DPRAM_WRITE_FIRST_EN
    logic          fwd_r;
    logic [dw-1:0] fwd_data_r;

    // Same-edge address match captured alongside the read so the new word can bypass the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_r      <= 1'b0;
            fwd_data_r <= {dw{1'b0}};
        end else if (rce) begin
            fwd_r      <= wce & we & (raddr == waddr);
            fwd_data_r <= di;
        end
    end

    // Bypass mux selecting forwarded write data over the stale array word
    always_comb begin
        rdata_s = rdata_r;
        if (fwd_r) begin
            rdata_s = fwd_data_r;
        end else begin
            rdata_s = rdata_r;
        end
    end
`else
    assign rdata_s = rdata_r;
`endif

    assign dout = oe ? rdata_s : {dw{1'b0}};

endmodule

// File: tb/tb_generic_dpram_1clk.sv
// Directed self-checking bench for generic_dpram_1clk (aw=8, dw=8).
module tb_generic_dpram_1clk;

    logic       clk;
    logic       rst;
    logic       rce;
    logic       oe;
    logic [7:0] raddr;
    logic [7:0] dout;
    logic       wce;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] di;

    int total;
    int bad;

    generic_dpram_1clk #(.aw(8), .dw(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .rce   (rce),
        .oe    (oe),
        .raddr (raddr),
        .dout  (dout),
        .wce   (wce),
        .we    (we),
        .waddr (waddr),
        .di    (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] conc_val(input int k);
        logic [7:0] v;
        v = 8'(k * 3 + 7);
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rce   = 1'b0;
        oe    = 1'b1;
        raddr = 8'h00;
        wce   = 1'b0;
        we    = 1'b0;
        waddr = 8'h00;
        di    = 8'h00;
        tick();
        tick();
        check_val("reset_do", dout, 8'h00);
        rst = 1'b0;

        // write 0xA5 to 0x10, then read it with one-edge latency
        wce = 1'b1; we = 1'b1; waddr = 8'h10; di = 8'hA5;
        tick();
        wce = 1'b0; we = 1'b0;
        rce = 1'b1; raddr = 8'h10;
        check_val("lat_before_edge", dout, 8'h00);
        tick();
        check_val("lat_after_edge", dout, 8'hA5);

        // we without wce must not write
        rce = 1'b0;
        wce = 1'b0; we = 1'b1; waddr = 8'h10; di = 8'h3C;
        tick();
        we = 1'b0;
        rce = 1'b1; raddr = 8'h10;
        tick();
        check_val("wce_gate", dout, 8'hA5);

        // rce low holds read data while the address moves
        rce = 1'b0; raddr = 8'h11;
        tick();
        check_val("rce_hold", dout, 8'hA5);

        // oe gating is combinational
        oe = 1'b0;
        #1;
        check_val("oe_off", dout, 8'h00);
        oe = 1'b1;
        #1;
        check_val("oe_on", dout, 8'hA5);

        // full sweep write then back-to-back read
        wce = 1'b1; we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            waddr = 8'(i);
            di    = 8'(i) ^ 8'h5A;
            tick();
        end
        wce = 1'b0; we = 1'b0;
        rce = 1'b1;
        for (int i = 0; i < 256; i++) begin
            raddr = 8'(i);
            tick();
            check_val($sformatf("sweep_%02h", i), dout, 8'(i) ^ 8'h5A);
        end

        // read-during-write on the same address
        wce = 1'b1; we = 1'b1; waddr = 8'h20; di = 8'h11; rce = 1'b0;
        tick();
        di = 8'h22; rce = 1'b1; raddr = 8'h20;
        tick();
`ifdef GENERIC_DPRAM_WRITE_FIRST_EN
        check_val("rdw_same_edge", dout, 8'h22);
`else
        check_val("rdw_same_edge", dout, 8'h11);
`endif
        wce = 1'b0; we = 1'b0;
        tick();
        check_val("rdw_next", dout, 8'h22);

        // concurrent ports: write k while reading k-1
        wce = 1'b1; we = 1'b1; waddr = 8'h40; di = conc_val(0); rce = 1'b0;
        tick();
        rce = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            waddr = 8'(8'h40 + k);
            di    = conc_val(k);
            raddr = 8'(8'h40 + k - 1);
            tick();
            check_val($sformatf("conc_%0d", k), dout, conc_val(k - 1));
        end
        wce = 1'b0; we = 1'b0;

        // reset mid-stream: immediate clear, no write while held, memory kept
        raddr = 8'h30;
        tick();
        check_val("pre_reset_read", dout, 8'h6A);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_reset", dout, 8'h00);
        wce = 1'b1; we = 1'b1; waddr = 8'h30; di = 8'hFF;
        tick();
        check_val("reset_held", dout, 8'h00);
        wce = 1'b0; we = 1'b0;
        rst = 1'b0;
        raddr = 8'h30;
        tick();
        check_val("post_reset_30", dout, 8'h6A);
        raddr = 8'h20;
        tick();
        check_val("post_reset_20", dout, 8'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generic_dpram_1clk.md
Name: generic_dpram_1clk

Overview:
Single-clock, simple dual-port synchronous RAM: one write port and one independent read port, both on the same clock.
- Storage for the generic FIFO family and other buffers that need a concurrent write and read each cycle.
- Read data is registered: one-cycle latency.
- An output-enable gate forces the output to zero when deasserted.

Parameters:
aw, 8, address width; depth = 2**aw words
dw, 8, data word width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset; clears the read data register only
rce  input  1  read clock enable; read register updates only when high
oe  input  1  output enable; gates do
raddr  input  aw  read address
do  output  dw  read data (registered, then gated by oe)
wce  input  1  write clock enable
we  input  1  write enable; write happens only when wce & we
waddr  input  aw  write address
di  input  dw  write data

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Memory array:
  - 2**aw words × dw bits.
  - Not cleared by rst.
  - Contents before first write are undefined; the bench must not check them.
- Write:
  - On posedge clk with rst low and wce=1 and we=1: mem[waddr] <= di.
  - Otherwise the memory holds.
  - No write occurs while rst is high.
- Read:
  - On posedge clk with rst low and rce=1: rdata <= mem[raddr].
  - rce=0: rdata holds its value.
  - Latency: address sampled at edge N, data visible after edge N.
- Output gating:
  - do = oe ? rdata : 0.
  - Purely combinational; no tristate.
- Reset:
  - rst rising drives rdata to 0 immediately, without waiting for clk.
  - do = 0 while reset is held, regardless of oe.
  - Release is synchronous in effect: the first read occurs on the first posedge with rst low.
  - Reset asserted mid-operation aborts a read in progress; memory contents are preserved.
- Read-during-write, same address, same edge:
  - Default (read-first): rdata receives the OLD stored word.
  - See Optional Feature for the alternative.
- Different addresses:
  - Read and write are fully independent.
  - Every cycle may carry one read and one write.
- Address wrap: addresses are aw bits wide, so no out-of-range access is possible.
- Synthesis target: inferable block RAM; the memory array has no reset logic.

Optional Feature:
Macro GENERIC_DPRAM_WRITE_FIRST_EN.
- Defined (write-first): when wce & we & rce are all high on the same edge and raddr == waddr, rdata <= di, i.e. the new data is forwarded.
  - Implemented as a registered compare plus bypass mux.
  - Memory write is unchanged.
- Undefined: read-first behaviour as above; no bypass logic is generated.

Test Plan:
- Reset: assert rst=1 asynchronously between clock edges, oe=1 → do becomes 0x00 before the next edge. Release rst, then read an unwritten address → bench ignores the value.
- Write/read latency: write di=0xA5 at waddr=0x10 (wce=we=1), next cycle raddr=0x10 with rce=1 → do=0xA5 exactly one edge after the address is sampled.
- Enables:
  - we=1, wce=0 at addr 0x10 with di=0x3C → later read returns 0xA5.
  - rce=0 while raddr changes → do holds its previous value.
  - oe=0 → do=0x00; oe=1 → rdata reappears with no clock edge.
- Full sweep: write mem[i]=i^0x5A for i=0..255 back-to-back, then read 0..255 back-to-back → each word matches, one-cycle offset. Includes the address wrap from 0xFF to 0x00.
- Read-during-write: mem[0x20]=0x11; same edge write 0x22 to 0x20 and read 0x20.
  - Macro undefined → do=0x11; next read → 0x22.
  - Macro defined → do=0x22.
- Concurrent independent ports: each cycle write addr k and read addr k-1 → reads always return previously written data.
- Reset mid-stream: reset mid-stream → do=0x00 immediately, memory contents intact afterwards.
